// File: rtl/pb_cond_pkg.sv
// Shared definitions for the push-button conditioner: edge-mode encodings and
// a width helper used to size the per-channel counters.
package pb_cond_pkg;

   localparam logic [1:0] MODE_RISE = 2'd0;
   localparam logic [1:0] MODE_FALL = 2'd1;
   localparam logic [1:0] MODE_BOTH = 2'd2;

   // Smallest width w (at least 1) with 2**w >= value.
   function automatic int clog2(input longint unsigned value);
      int              w;
      longint unsigned cap;
      w   = 1;
      cap = 2;
      while (cap < value) begin
         w   = w + 1;
         cap = cap << 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: synchroniser chain, stable-time debouncer and an
// edge/auto-repeat pulse generator driving registered LEVEL and PULSE.
module pb_channel
   import pb_cond_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 1000000,
   parameter int MODE        = 0,
   parameter int REPEAT      = 0,
   parameter int REP_DELAY   = 50000000,
   parameter int REP_RATE    = 10000000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic PB,
   input  logic EN,
   output logic LEVEL,
   output logic PULSE
);

   localparam int DEB_W = clog2(longint'(DEB_CYCLES) + 1);
   localparam int REP_W = clog2(longint'(REP_DELAY) + 1);

   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REP_DELAY);
   localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_RATE);
   localparam logic [1:0]       MODE_SEL   = 2'(MODE);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [DEB_W-1:0]       deb_q, deb_d;
   logic                   level_d;
   logic [REP_W-1:0]       rep_q, rep_d, rep_inc;
   logic                   rise, fall, edge_hit, rep_hit, pulse_d;

   assign s       = sync_q[SYNC_STAGES-1];
   assign rep_inc = rep_q + 1'b1;

   // NOTE: every combinational output is given a default first so no latch is inferred.
   always_comb begin
      deb_d   = '0;
      level_d = LEVEL;
      if (s != LEVEL) begin
         if (deb_q == DEB_LAST) begin
            level_d = s;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end
   end

   always_comb begin
      rise     = ~LEVEL & level_d;
      fall     = LEVEL & ~level_d;
      edge_hit = 1'b0;
      case (MODE_SEL)
         MODE_RISE: edge_hit = rise;
         MODE_FALL: edge_hit = fall;
         default:   edge_hit = rise | fall;
      endcase
   end

   // Repeat counting only runs while the level stays high across the edge, so
   // the press edge, the release edge and EN=0 all leave the counter at zero
   // and a repeat can never land on the same cycle as an edge pulse.
   always_comb begin
      rep_d   = '0;
      rep_hit = 1'b0;
      if (REPEAT != 0 && EN && LEVEL && level_d) begin
         if (rep_inc == REP_FIRE) begin
            rep_hit = 1'b1;
            rep_d   = REP_RELOAD;
         end else begin
            rep_d = rep_inc;
         end
      end
      pulse_d = EN & (edge_hit | rep_hit);
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q <= '0;
         deb_q  <= '0;
         LEVEL  <= 1'b0;
         rep_q  <= '0;
         PULSE  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], PB};
         deb_q  <= deb_d;
         LEVEL  <= level_d;
         rep_q  <= rep_d;
         PULSE  <= pulse_d;
      end
   end

endmodule

// File: rtl/pb_conditioner.sv
// N-channel push-button conditioner: independent pb_channel slices whose
// LEVEL and PULSE bits are concatenated onto the output buses.
module pb_conditioner
   import pb_cond_pkg::*;
#(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 1000000,
   parameter int MODE        = 0,
   parameter int REPEAT      = 0,
   parameter int REP_DELAY   = 50000000,
   parameter int REP_RATE    = 10000000
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [N-1:0] PB,
   input  logic         EN,
   output logic [N-1:0] LEVEL,
   output logic [N-1:0] PULSE
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("pb_conditioner: SYNC_STAGES must be >= 2");
   end
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("pb_conditioner: DEB_CYCLES must be >= 1");
   end
   if (MODE < 0 || MODE > int'(MODE_BOTH)) begin : g_bad_mode
      $error("pb_conditioner: MODE must be 0, 1 or 2");
   end
   if (REPEAT == 1 && (REP_RATE < 1 || REP_DELAY < 1 || REP_RATE > REP_DELAY)) begin : g_bad_rep
      $error("pb_conditioner: need 1 <= REP_RATE <= REP_DELAY when REPEAT = 1");
   end

   for (genvar i = 0; i < N; i++) begin : g_ch
      pb_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_CYCLES  (DEB_CYCLES),
         .MODE        (MODE),
         .REPEAT      (REPEAT),
         .REP_DELAY   (REP_DELAY),
         .REP_RATE    (REP_RATE)
      ) u_ch (
         .CLK   (CLK),
         .RST_N (RST_N),
         .PB    (PB[i]),
         .EN    (EN),
         .LEVEL (LEVEL[i]),
         .PULSE (PULSE[i])
      );
   end

endmodule
